// File: rtl/io_interrupt_controller.sv
// io_interrupt_controller: edge-triggered interrupt FSM with pulse holdoff,
// a one-word processor input register and a processor output FIFO.
module io_interrupt_controller #(
    parameter int NUM_SRC    = 4,
    parameter int HOLDOFF    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            ext_irq_req,
    output logic                          interrupt_signal,
    output logic [$clog2(NUM_SRC)-1:0]    irq_id,
    input  logic [15:0]                   ext_in_data,
    input  logic                          ext_in_valid,
    output logic                          ext_in_ready,
    output logic [15:0]                   input_port,
    output logic                          input_avail,
    input  logic                          in_read,
    input  logic [15:0]                   out_port,
    input  logic                          out_en,
    output logic [15:0]                   ext_out_data,
    output logic                          ext_out_valid,
    input  logic                          ext_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int IW   = $clog2(NUM_SRC);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int CW   = $clog2(HOLDOFF) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] pending, req_q, clr_mask;
    logic [CW-1:0]      cnt, cnt_dec;
    logic [IW-1:0]      lowest;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop, full;

    always_comb begin
        lowest = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pending[i]) lowest = IW'(i);
    end

    assign interrupt_signal = (state == FIRE);
    assign clr_mask = (state == FIRE) ? (NUM_SRC'(1) << irq_id) : '0;
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - 1'b1;

    // The holdoff count starts at FIRE entry so the idle gap is exactly HOLDOFF cycles.
    // A fresh edge on the serviced source is OR-ed after the clear, so the set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            req_q   <= ext_irq_req;
            cnt     <= '0;
            irq_id  <= '0;
        end else begin
            req_q   <= ext_irq_req;
            pending <= (pending & ~clr_mask) | (ext_irq_req & ~req_q);
            case (state)
                IDLE: if (|pending) begin
                    state  <= FIRE;
                    irq_id <= lowest;
                    cnt    <= CW'(HOLDOFF - 1);
                end
                FIRE: begin
                    state <= HOLD;
                    cnt   <= cnt_dec;
                end
                default: begin
                    state <= (cnt == '0) ? IDLE : HOLD;
                    cnt   <= cnt_dec;
                end
            endcase
        end
    end

    assign ext_in_ready = !input_avail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            input_port  <= '0;
            input_avail <= 1'b0;
        end else if (ext_in_valid && !input_avail) begin
            input_port  <= ext_in_data;
            input_avail <= 1'b1;
        end else if (in_read) begin
            input_avail <= 1'b0;
        end
    end

    assign full          = (fifo_count == NW'(FIFO_DEPTH));
    assign ext_out_valid = (fifo_count != '0);
    assign ext_out_data  = mem[rd_ptr];
    assign pop           = ext_out_valid && ext_out_ready;
    assign push          = out_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= out_port;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
            overflow   <= overflow | (out_en && !push);
        end
    end
endmodule

// File: tb/tb_io_interrupt_controller.sv
// tb_io_interrupt_controller: directed scenarios plus randomized traffic checked
// against a cycle-indexed behavioural model of the controller.
module tb_io_interrupt_controller;
    localparam int NS = 4;
    localparam int HO = 4;
    localparam int FD = 4;
    localparam int IW = $clog2(NS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NS-1:0] ext_irq_req = '0;
    logic interrupt_signal;
    logic [IW-1:0] irq_id;
    logic [15:0] ext_in_data = '0;
    logic ext_in_valid = 1'b0;
    logic ext_in_ready;
    logic [15:0] input_port;
    logic input_avail;
    logic in_read = 1'b0;
    logic [15:0] out_port = '0;
    logic out_en = 1'b0;
    logic [15:0] ext_out_data;
    logic ext_out_valid;
    logic ext_out_ready = 1'b0;
    logic [$clog2(FD):0] fifo_count;
    logic overflow;

    io_interrupt_controller #(.NUM_SRC(NS), .HOLDOFF(HO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .ext_irq_req(ext_irq_req),
        .interrupt_signal(interrupt_signal), .irq_id(irq_id),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .input_port(input_port), .input_avail(input_avail), .in_read(in_read),
        .out_port(out_port), .out_en(out_en),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: pulses are predicted from cycle numbers (last pulse + HOLDOFF idle cycles).
    logic [NS-1:0] m_pend, m_prev;
    bit m_fire;
    int m_id, m_last, cyc;
    logic [15:0] q[$];
    bit m_avail, m_ovf;
    logic [15:0] m_in;

    task automatic tick();
        logic [NS-1:0] np;
        bit nf, pu, po;
        int nid;
        if (!rst) begin
            m_pend = '0; m_prev = ext_irq_req; m_fire = 0; m_id = 0; m_last = -100;
            q.delete(); m_avail = 0; m_in = '0; m_ovf = 0;
        end else begin
            nf = !m_fire && (cyc >= m_last + HO) && (m_pend != '0);
            nid = m_id;
            if (nf) for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) nid = i;
            np = m_pend;
            if (m_fire) np[m_id] = 1'b0;
            np = np | (ext_irq_req & ~m_prev);
            if (nf) m_last = cyc + 1;
            m_pend = np; m_prev = ext_irq_req; m_fire = nf; m_id = nid;
            po = (q.size() != 0) && ext_out_ready;
            pu = out_en && (q.size() < FD || po);
            if (out_en && !pu) m_ovf = 1;
            if (po) void'(q.pop_front());
            if (pu) q.push_back(out_port);
            if (ext_in_valid && !m_avail) begin
                m_in = ext_in_data; m_avail = 1;
            end else if (in_read) m_avail = 0;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; ext_irq_req = '0; ext_in_valid = 0; in_read = 0; out_en = 0; ext_out_ready = 0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (interrupt_signal !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", interrupt_signal); end
        if (irq_id !== '0) begin bad++; $display("FAIL rst_id got=%0d exp=0", irq_id); end
        if (input_avail !== 1'b0) begin bad++; $display("FAIL rst_avail got=%b exp=0", input_avail); end
        if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ext_in_ready); end
        if (input_port !== 16'h0) begin bad++; $display("FAIL rst_port got=%h exp=0000", input_port); end
        if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ext_out_valid); end
        if (fifo_count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_irq_basic();
        int pc[$];
        int pid[$];
        do_reset();
        ext_irq_req = 4'b0101;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (interrupt_signal) begin pc.push_back(k); pid.push_back(int'(irq_id)); end
        end
        ext_irq_req = '0;
        pc.push_back(-1); pc.push_back(-1); pid.push_back(-1); pid.push_back(-1);
        total += 5;
        if (pc.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=2", pc.size() - 2); end
        if (pc[0] != 2) begin bad++; $display("FAIL basic_t0 got=%0d exp=2", pc[0]); end
        if (pid[0] != 0) begin bad++; $display("FAIL basic_id0 got=%0d exp=0", pid[0]); end
        if (pc[1] != 7) begin bad++; $display("FAIL basic_t1 got=%0d exp=7", pc[1]); end
        if (pid[1] != 2) begin bad++; $display("FAIL basic_id1 got=%0d exp=2", pid[1]); end
    endtask

    task automatic test_set_wins();
        int pc[$];
        int pid[$];
        do_reset();
        ext_irq_req = 4'b0010;
        tick();
        ext_irq_req = 4'b0000;
        tick();
        total += 2;
        if (interrupt_signal !== 1'b1) begin bad++; $display("FAIL sw_first got=%b exp=1", interrupt_signal); end
        if (irq_id !== 2'd1) begin bad++; $display("FAIL sw_first_id got=%0d exp=1", irq_id); end
        ext_irq_req = 4'b0010;
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (interrupt_signal) begin pc.push_back(k); pid.push_back(int'(irq_id)); end
        end
        ext_irq_req = '0;
        pc.push_back(-1); pid.push_back(-1);
        total += 3;
        if (pc.size() != 2) begin bad++; $display("FAIL sw_count got=%0d exp=1", pc.size() - 1); end
        if (pc[0] != 7) begin bad++; $display("FAIL sw_t got=%0d exp=7", pc[0]); end
        if (pid[0] != 1) begin bad++; $display("FAIL sw_id got=%0d exp=1", pid[0]); end
    endtask

    task automatic test_input_port();
        do_reset();
        ext_in_data = 16'hBEEF; ext_in_valid = 1;
        tick();
        total += 3;
        if (input_port !== 16'hBEEF) begin bad++; $display("FAIL in_data got=%h exp=beef", input_port); end
        if (input_avail !== 1'b1) begin bad++; $display("FAIL in_avail got=%b exp=1", input_avail); end
        if (ext_in_ready !== 1'b0) begin bad++; $display("FAIL in_ready got=%b exp=0", ext_in_ready); end
        ext_in_data = 16'h1234;
        tick();
        total++;
        if (input_port !== 16'hBEEF) begin bad++; $display("FAIL in_refuse got=%h exp=beef", input_port); end
        ext_in_valid = 0; in_read = 1;
        tick();
        tick();
        in_read = 0;
        total += 3;
        if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL in_read_ready got=%b exp=1", ext_in_ready); end
        if (input_avail !== 1'b0) begin bad++; $display("FAIL in_read_avail got=%b exp=0", input_avail); end
        if (input_port !== 16'hBEEF) begin bad++; $display("FAIL in_keep got=%h exp=beef", input_port); end
        ext_in_valid = 1;
        tick();
        ext_in_valid = 0;
        total++;
        if (input_port !== 16'h1234) begin bad++; $display("FAIL in_second got=%h exp=1234", input_port); end
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            out_port = 16'(k); out_en = 1;
            tick();
        end
        out_en = 0;
        total += 2;
        if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        ext_out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (ext_out_data !== 16'(k) || ext_out_valid !== 1'b1) begin
                bad++; $display("FAIL ovf_drain%0d got=%h/%b exp=%h/1", k, ext_out_data, ext_out_valid, 16'(k));
            end
            tick();
        end
        ext_out_ready = 0;
        total += 2;
        if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", ext_out_valid); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            out_port = 16'h10 + 16'(k); out_en = 1;
            tick();
        end
        ext_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            exp_v = 16'h10 + 16'(k);
            out_port = 16'h14 + 16'(k);
            total++;
            if (ext_out_data !== exp_v) begin bad++; $display("FAIL b2b_head%0d got=%h exp=%h", k, ext_out_data, exp_v); end
            tick();
            total += 2;
            if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=4", k, fifo_count); end
            if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf%0d got=%b exp=0", k, overflow); end
        end
        out_en = 0;
        for (int k = 0; k < 4; k++) begin
            exp_v = 16'h13 + 16'(k);
            total++;
            if (ext_out_data !== exp_v) begin bad++; $display("FAIL b2b_drain%0d got=%h exp=%h", k, ext_out_data, exp_v); end
            tick();
        end
        ext_out_ready = 0;
        total++;
        if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", ext_out_valid); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        ext_in_data = 16'hA5A5; ext_in_valid = 1;
        out_port = 16'h11; out_en = 1;
        ext_irq_req = 4'b0010;
        tick();
        ext_in_valid = 0; out_port = 16'h22;
        tick();
        out_en = 0; ext_irq_req = 4'b0011;
        tick();
        total += 2;
        if (fifo_count !== 3'd2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", fifo_count); end
        if (irq_id !== 2'd1) begin bad++; $display("FAIL mid_pre_id got=%0d exp=1", irq_id); end
        rst = 0;
        tick();
        total += 7;
        if (interrupt_signal !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b exp=0", interrupt_signal); end
        if (irq_id !== '0) begin bad++; $display("FAIL mid_id got=%0d exp=0", irq_id); end
        if (fifo_count !== '0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        if (ext_out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", ext_out_valid); end
        if (input_port !== 16'h0) begin bad++; $display("FAIL mid_port got=%h exp=0000", input_port); end
        if (ext_in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", ext_in_ready); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
        rst = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (interrupt_signal) pulses++;
        end
        ext_irq_req = '0;
        total++;
        if (pulses != 0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=0", pulses); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) ext_irq_req = NS'($urandom);
            ext_in_valid = 1'($urandom);
            ext_in_data = 16'($urandom);
            in_read = ($urandom_range(0, 2) == 0);
            out_en = 1'($urandom);
            out_port = 16'($urandom);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            tick();
            total += 8;
            if (interrupt_signal !== m_fire) begin bad++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, interrupt_signal, m_fire); end
            if (irq_id !== IW'(m_id)) begin bad++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, irq_id, m_id); end
            if (input_avail !== m_avail) begin bad++; $display("FAIL rnd_avail c=%0d got=%b exp=%b", c, input_avail, m_avail); end
            if (input_port !== m_in) begin bad++; $display("FAIL rnd_port c=%0d got=%h exp=%h", c, input_port, m_in); end
            if (ext_in_ready !== !m_avail) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ext_in_ready, !m_avail); end
            if (fifo_count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fifo_count, q.size()); end
            if (ext_out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ext_out_valid, q.size() != 0); end
            if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, overflow, m_ovf); end
            if (q.size() != 0) begin
                total++;
                if (ext_out_data !== q[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, ext_out_data, q[0]); end
            end
        end
        rst = 1;
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_irq_basic();
        test_set_wins();
        test_input_port();
        test_fifo_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_interrupt_controller.md
IO_INTERRUPT_CONTROLLER -- requirements
Module: io_interrupt_controller

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_SRC, 4: external interrupt sources.
- HOLDOFF, 4: minimum idle cycles after an interrupt pulse before the next one.
- FIFO_DEPTH, 4: output-port FIFO entries; power of two.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- ext_irq_req, in, NUM_SRC: level request lines from devices, edge-detected.
- interrupt_signal, out, 1: interrupt pulse to the processor.
- irq_id, out, log2(NUM_SRC): index of the source serviced by the last pulse.
- ext_in_data, in, 16: device data for the processor input port.
- ext_in_valid, in, 1: device data valid.
- ext_in_ready, out, 1: holding register can accept data.
- input_port, out, 16: value presented to the processor input port.
- input_avail, out, 1: input_port holds unread data.
- in_read, in, 1: processor consumed input_port (one-cycle strobe).
- out_port, in, 16: processor output-port value.
- out_en, in, 1: processor output-port write strobe.
- ext_out_data, out, 16: FIFO head to the device.
- ext_out_valid, out, 1: FIFO non-empty.
- ext_out_ready, in, 1: device accepts the head.
- fifo_count, out, log2(FIFO_DEPTH)+1: current FIFO occupancy.
- overflow, out, 1: sticky flag; an out_en write was dropped.

Function
REQ-003 The block SHALL set pending[i] one cycle after ext_irq_req[i] goes 0->1, comparing against a registered copy of ext_irq_req.
REQ-004 The block SHALL run an interrupt FSM with states IDLE, FIRE and HOLD.
- IDLE: go to FIRE on the next edge if any pending bit is set.
- FIRE: interrupt_signal=1 for exactly one cycle. irq_id is loaded with the lowest-index pending bit and holds that value until the next FIRE. That pending bit is cleared. The holdoff counter loads HOLDOFF-1. Next state is HOLD.
- HOLD: decrement the counter each cycle. Go to IDLE on the cycle the counter is 0.
REQ-005 When a new rising edge on source i coincides with FIRE clearing pending[i], the set SHALL win and pending[i] SHALL remain 1.
REQ-006 Pulse spacing SHALL be HOLDOFF+1 cycles minimum. Latency from a request edge to interrupt_signal SHALL be 2 cycles when the FSM is idle.
REQ-007 ext_in_ready SHALL equal !input_avail.
- On ext_in_valid&&ext_in_ready, input_port<=ext_in_data and input_avail<=1.
- in_read clears input_avail; input_port keeps its value.
- in_read while input_avail=0 SHALL be ignored.
REQ-008 The block SHALL push out_port into the FIFO on out_en when not full.
- out_en while full with no pop: the write is dropped and overflow<=1. overflow clears only on reset.
REQ-009 ext_out_valid SHALL equal (fifo_count!=0), and ext_out_data SHALL show the head entry combinationally from the read pointer.
- A pop occurs on ext_out_valid&&ext_out_ready.
REQ-010 Push and pop in the same cycle SHALL both take effect and leave fifo_count unchanged, including when full (no overflow).
- When empty, only the push takes effect.
REQ-011 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-012 While rst=0 at a clk edge, the block SHALL clear:
- FSM to IDLE;
- pending, the edge-detect register and the holdoff counter;
- interrupt_signal, irq_id, input_port, input_avail, FIFO pointers, fifo_count and overflow.
After reset, ext_in_ready=1 and ext_out_valid=0.
REQ-013 Reset asserted mid-operation (FIRE, HOLD, or non-empty FIFO) SHALL abandon all state in that cycle. No interrupt pulse SHALL be emitted for requests pending before reset.
REQ-014 A request line held high through reset release SHALL NOT raise an interrupt; the edge register resets to 0 only if the line is low at release, otherwise the line must fall and rise again.

Verification
REQ-015 The bench SHALL cover these directed scenarios (stimulus -> required response):
- ext_irq_req 0000->0101 at cycle 0 -> pulse at cycle 2 with irq_id=0; pulse at cycle 7 with irq_id=2 (HOLDOFF=4); no further pulses.
- Source 1 re-edges in the same cycle its FIRE clears it -> a second pulse with irq_id=1 after holdoff.
- ext_in_data=0xBEEF with valid -> input_port=0xBEEF, input_avail=1, ext_in_ready=0; a second word is refused until in_read; after in_read, ext_in_ready=1.
- Five out_en writes 0x0001..0x0005 with ext_out_ready=0 -> fifo_count=4, overflow=1; draining outputs 0x0001..0x0004 in order; then ext_out_valid=0.
- FIFO full with out_en and ext_out_ready both high for 3 cycles -> fifo_count stays 4, overflow stays 0, output order preserved across pointer wrap.
- rst=0 during HOLD with FIFO count 2 -> next cycle all outputs are at reset values and no pulse follows.
